// File: rtl/locked_pipe_adder.sv
// Key-locked adder: (a ^ key) + b + cin, CHUNK bits per stage, valid/ready on both sides.
// Latency STAGES cycles; on output stall every stage holds and in_ready drops.
module locked_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_bit,
    input  logic             key_shift,
    output logic             key_valid,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             cout
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_cfg
        $error("locked_pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [WIDTH-1:0] key;
    logic [CNT_W-1:0] key_cnt;
    logic             stall;

    // Count saturates at WIDTH; further shifts only roll the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key     <= '0;
            key_cnt <= '0;
        end else if (key_shift) begin
            key <= {key[WIDTH-2:0], key_bit};
            if (!key_valid) begin
                key_cnt <= key_cnt + CNT_W'(1);
            end
        end
    end

    assign key_valid = (key_cnt == CNT_W'(WIDTH));
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = key_valid & ~stall;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic             vld_r;
        logic             carry_r;
        logic [WIDTH-1:0] sum_r;
        logic             v_src;
        logic             c_src;
        logic [WIDTH-1:0] x_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic [WIDTH-1:0] s_nxt;
        logic [CHUNK:0]   chunk_sum;

        // Stage 0 binds the key as registered before any same-cycle shift.
        if (s == 0) begin : g_head
            assign v_src = in_valid & in_ready;
            assign c_src = cin;
            assign x_src = a ^ key;
            assign b_src = b;
            assign s_src = '0;
        end else begin : g_link
            assign v_src = g_stage[s-1].vld_r;
            assign c_src = g_stage[s-1].carry_r;
            assign x_src = g_stage[s-1].g_fwd.x_r;
            assign b_src = g_stage[s-1].g_fwd.b_r;
            assign s_src = g_stage[s-1].sum_r;
        end

        assign chunk_sum = {1'b0, CHUNK'(x_src >> (s * CHUNK))}
                         + {1'b0, CHUNK'(b_src >> (s * CHUNK))}
                         + {{CHUNK{1'b0}}, c_src};

        always_comb begin
            s_nxt = s_src;
            s_nxt[s*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end

        // Data only loads with a valid beat so the output holds through bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r   <= 1'b0;
                carry_r <= 1'b0;
                sum_r   <= '0;
            end else if (!stall) begin
                vld_r <= v_src;
                if (v_src) begin
                    carry_r <= chunk_sum[CHUNK];
                    sum_r   <= s_nxt;
                end
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] x_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    x_r <= '0;
                    b_r <= '0;
                end else if (!stall && v_src) begin
                    x_r <= x_src;
                    b_r <= b_src;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_r;
    assign cout      = g_stage[STAGES-1].carry_r;
    assign sum       = {g_stage[STAGES-1].carry_r, g_stage[STAGES-1].sum_r};

endmodule

// File: tb/tb_locked_pipe_adder.sv
// Bench for locked_pipe_adder (WIDTH=16, CHUNK=4): scoreboard monitor plus per-scenario tasks.
module tb_locked_pipe_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_bit;
    logic         key_shift;
    logic         key_valid;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [W:0]   exp_q[$];
    logic [W:0]   sb_exp;
    logic [W-1:0] m_key;

    locked_pipe_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .key_bit(key_bit), .key_shift(key_shift),
        .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    // Scoreboard: inputs are stable around the edge, so sampling at negedge sees what the edge sees.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_key = '0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_beat got %h want none", sum);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (sum !== sb_exp || cout !== sb_exp[W]) begin
                        errors++;
                        $display("FAIL sb_result got sum=%h cout=%b want sum=%h cout=%b",
                                 sum, cout, sb_exp, sb_exp[W]);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({1'b0, a ^ m_key} + {1'b0, b} + {{W{1'b0}}, cin});
            if (key_shift)
                m_key = {m_key[W-2:0], key_bit};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; key_shift = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load_key(input logic [W-1:0] k);
        for (int i = 0; i < W; i++) begin
            key_shift = 1'b1;
            key_bit   = k[W-1-i];
            tick();
        end
        key_shift = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d beats outstanding want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (key_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_key got key_valid=%b in_ready=%b want 0 0", key_valid, in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got out_valid=%b sum=%h cout=%b want 0 0 0", out_valid, sum, cout);
        end
    endtask

    task automatic test_key_load();
        logic [W-1:0] k;
        k = 16'hAAAA;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < W - 1; i++) begin
            key_shift = 1'b1;
            key_bit   = k[W-1-i];
            tick();
        end
        key_shift = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL key_15_bits got key_valid=%b in_ready=%b want 0 0", key_valid, in_ready);
        end
        key_shift = 1'b1;
        key_bit   = k[0];
        tick();
        key_shift = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL key_16_bits got key_valid=%b in_ready=%b want 1 1", key_valid, in_ready);
        end
    endtask

    task automatic test_latency_xor();
        in_valid = 1'b1; a = 16'h0005; b = 16'h000E; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early edge+%0d got out_valid=%b want 0", k, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 17'h0AABD || cout !== 1'b0) begin
            errors++;
            $display("FAIL latency_xor got out_valid=%b sum=%h cout=%b want 1 0aabd 0", out_valid, sum, cout);
        end
        drain("latency_xor");
    endtask

    task automatic test_carry_out();
        int waited;
        apply_reset();
        load_key(16'h0000);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 17'h10001 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_out got out_valid=%b sum=%h cout=%b want 1 10001 1", out_valid, sum, cout);
        end
        drain("carry_out");
    endtask

    task automatic test_stall_stream();
        int idx;
        int cyc;
        logic acc;
        logic held_ok;
        logic [W:0] held;
        apply_reset();
        load_key(16'($urandom));
        idx = 0; cyc = 0; held_ok = 1'b0; held = '0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        while (idx < 8 && cyc < 100) begin
            in_valid  = 1'b1;
            out_ready = !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            acc = in_ready;
            if (!out_ready && out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready);
                end
                if (held_ok) begin
                    checks++;
                    if (sum !== held) begin
                        errors++;
                        $display("FAIL stall_sum_hold cyc %0d got %h want %h", cyc, sum, held);
                    end
                end
                held = sum;
                held_ok = 1'b1;
            end
            tick();
            if (acc) begin
                idx++;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            cyc++;
        end
        checks++;
        if (idx != 8) begin
            errors++;
            $display("FAIL stall_accepted got %0d beats want 8", idx);
        end
        drain("stall_stream");
    endtask

    task automatic test_key_binding();
        apply_reset();
        load_key(16'h1234);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h1111; cin = 1'b0;
        tick();
        in_valid = 1'b0; key_shift = 1'b1; key_bit = 1'b1;
        tick();
        key_shift = 1'b0;
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h1111; cin = 1'b1;
        tick();
        // Accept and shift in the same cycle: the beat keeps the pre-shift key.
        key_shift = 1'b1; key_bit = 1'b0; a = 16'h8001; b = 16'h7FFF; cin = 1'b0;
        tick();
        in_valid = 1'b0; key_shift = 1'b0;
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL key_roll_valid got %b want 1", key_valid);
        end
        drain("key_binding");
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
        end
        rst = 1'b1; key_shift = 1'b1; key_bit = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; key_shift = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || key_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight got out_valid=%b key_valid=%b sum=%h cout=%b want 0 0 0 0",
                     out_valid, key_valid, sum, cout);
        end
        load_key(16'hC3A5);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale cyc %0d got out_valid=%b want 0", i, out_valid);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; key_bit = 1'b0; key_shift = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        test_reset();
        test_key_load();
        test_latency_xor();
        test_carry_out();
        test_stall_stream();
        test_key_binding();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
